stack_seq_ctrl: RTL and testbench
=================================

// Module: stack_seq_ctrl
// PURPOSE
//  Sequences the hardware operand stack of the stack-MIPS core. Accepts push/pop/replace strobes from the
//  core controller and keeps the top-of-stack (TOS) in a register. Entries below TOS live in a
//  synchronous-read stack RAM. Manages count, full/empty, sticky overflow/underflow and the 1-cycle refill
//  after a pop. Sits between the controller's Push/Pop/ToS strobes and the datapath's stack operand bus.
// PARAMETERS
//  DATA_W   8    width of one stack entry
//  DEPTH    16   max entries incl. TOS register (RAM holds DEPTH-1)
//  AW       4    RAM address width = clog2(DEPTH); derived, do not override
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  push       in   1       push request, sampled when ready=1
//  pop        in   1       pop request, sampled when ready=1
//  push_data  in   DATA_W  value to push
//  clr_err    in   1       clears overflow/underflow flags
//  ready      out  1       1 = request accepted this cycle
//  tos_data   out  DATA_W  current TOS (tos_q); pop result in the accept cycle
//  count      out  AW+1    live entries, 0..DEPTH
//  empty      out  1       count==0
//  full       out  1       count==DEPTH
//  overflow   out  1       sticky: push attempted while full
//  underflow  out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, tos_q=0, count=0, overflow=underflow=0, ready=1, empty=1, full=0.
//   RAM contents are not reset.
//  RAM layout: entry i below TOS at address count-1-i; addresses 0..count-2 valid.
//  FSM states: IDLE, REFILL. ready = (state==IDLE). Requests while ready=0 are ignored; controller must hold.
//  IDLE, push only, !full: if count>=1 write tos_q -> RAM[count-1]; tos_q<=push_data; count+1. 1 cycle.
//  IDLE, push only, full: no state change; overflow<=1.
//  IDLE, pop only, count>=2: tos_data shows popped value this cycle; RAM read addr count-2; count-1;
//   -> REFILL.
//  IDLE, pop only, count==1: tos_q<=0, count<=0, stay IDLE (no RAM access).
//  IDLE, pop only, empty: no change; underflow<=1; tos_data=0.
//  IDLE, push&pop (replace): tos_q<=push_data, count unchanged, no RAM access; popped value = old tos_q.
//   When empty: behaves as a push (count 0->1), underflow not set.
//  REFILL: tos_q<=ram_rdata; -> IDLE. Latency: pop then next request no earlier than pop+2 cycles.
//  clr_err: flags cleared next edge; a same-cycle error event wins (flag stays 1).
//  Async reset mid-REFILL: refill discarded, all reset values above.
//  count arithmetic is AW+1 bits, never wraps; RAM address is AW bits.
// STRUCTURE
//  stack_defs.vh: state encodings (ST_IDLE=1'b0, ST_REFILL=1'b1) and default DATA_W/DEPTH localparams,
//   shared with the Datapath.
//  One sub-module: stack_ram (DEPTH x DATA_W, sync write, sync read, 1-cycle latency, single port).
//  All control (FSM, count, flags, tos_q) in stack_seq_ctrl.
// TESTING
//  1 reset, push 0x11,0x22,0x33 -> count=3, tos=0x33, RAM[0]=0x11, RAM[1]=0x22, ready always 1.
//  2 from 1, pop -> tos_data=0x33 in accept cycle, ready=0 one cycle, then tos=0x22, count=2;
//    pop,pop -> count=0, empty=1.
//  3 pop when empty -> underflow=1, count=0; clr_err -> underflow=0 next cycle.
//  4 push 16 values (DEPTH=16) -> full=1; 17th push -> overflow=1, tos unchanged, count=16;
//    then 16 pops return values LIFO.
//  5 push 0x05 then push&pop 0x09 -> tos=0x09, count=1, no ready drop;
//    push&pop when empty -> count=1, underflow=0.
//  6 assert rst low during REFILL -> count=0, tos=0, ready=1 immediately; no stale refill after release.

Source files
------------

// File: rtl/stack_seq_ctrl_pkg.sv
// Shared definitions for the operand-stack sequencer: FSM encoding and default sizing.
package stack_seq_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/stack_seq_ctrl_ram.sv
// Single-port stack RAM: synchronous write, synchronous read with one cycle of latency.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 15,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_seq_ctrl.sv
// Operand-stack sequencer: TOS held in a register, lower entries in stack_ram,
// one REFILL cycle after a pop that needs a RAM read.
module stack_seq_ctrl
  import stack_seq_ctrl_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              clr_err_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] tos_data_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output state_e            state_o
);

  // Handshake: a request (push_i/pop_i) is taken on any rising edge where ready_o=1;
  // while ready_o=0 requests are ignored and the controller must hold them.

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic              idle, push_only, pop_only, replace, full, empty;
  logic              ram_we, ram_re;
  logic [CW-1:0]     cnt_m1, cnt_m2;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign idle      = (state_q == ST_IDLE);
  assign push_only = push_i & ~pop_i;
  assign pop_only  = pop_i & ~push_i;
  assign replace   = push_i & pop_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign cnt_m1    = count_q - CW'(1);
  assign cnt_m2    = count_q - CW'(2);

  // The old TOS spills to the slot just below it; a pop reads the new TOS from one slot lower.
  assign ram_we    = idle & push_only & ~full & ~empty;
  assign ram_re    = idle & pop_only & (count_q >= CW'(2));
  assign ram_addr  = ram_we ? cnt_m1[AW-1:0] : cnt_m2[AW-1:0];

  stack_ram #(
    .DATA_W (DATA_W),
    .WORDS  (DEPTH - 1),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (tos_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = ovf_q & ~clr_err_i;
    unf_d   = unf_q & ~clr_err_i;
    if (state_q == ST_REFILL) begin
      tos_d   = ram_rdata;
      state_d = ST_IDLE;
    end else if (replace) begin
      tos_d = push_data_i;
      if (empty) count_d = CW'(1);
    end else if (push_only) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        tos_d   = push_data_i;
        count_d = count_q + CW'(1);
      end
    end else if (pop_only) begin
      if (empty) begin
        unf_d = 1'b1;
      end else if (count_q == CW'(1)) begin
        tos_d   = '0;
        count_d = '0;
      end else begin
        count_d = cnt_m1;
        state_d = ST_REFILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tos_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ready_o     = idle;
  assign tos_data_o  = tos_q;
  assign count_o     = count_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: reference stack model plus a queue of expected pop results.
module tb_stack_seq_ctrl;
  import stack_seq_ctrl_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              push_i = 1'b0, pop_i = 1'b0, clr_err_i = 1'b0;
  logic [DATA_W-1:0] push_data_i = '0;
  logic              ready_o, empty_o, full_o, overflow_o, underflow_o;
  logic [DATA_W-1:0] tos_data_o;
  logic [CW-1:0]     count_o;
  state_e            state_o;

  logic [DATA_W-1:0] mdl[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf = 1'b0, m_unf = 1'b0;
  int                checks = 0, errors = 0;

  stack_seq_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push_i(push_i), .pop_i(pop_i),
    .push_data_i(push_data_i), .clr_err_i(clr_err_i), .ready_o(ready_o),
    .tos_data_o(tos_data_o), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mdl.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [DATA_W-1:0] etos;
    etos = (mdl.size() > 0) ? mdl[mdl.size()-1] : '0;
    checks++;
    if (count_o !== CW'(mdl.size())) begin
      errors++; $display("FAIL %s count got %0d exp %0d", tag, count_o, mdl.size());
    end
    checks++;
    if (tos_data_o !== etos) begin
      errors++; $display("FAIL %s tos got %h exp %h", tag, tos_data_o, etos);
    end
    checks++;
    if (empty_o !== (mdl.size() == 0) || full_o !== (mdl.size() == DEPTH)) begin
      errors++; $display("FAIL %s empty/full got %b%b exp %b%b", tag, empty_o, full_o,
                         mdl.size() == 0, mdl.size() == DEPTH);
    end
    checks++;
    if (overflow_o !== m_ovf || underflow_o !== m_unf) begin
      errors++; $display("FAIL %s flags got ovf=%b unf=%b exp ovf=%b unf=%b", tag,
                         overflow_o, underflow_o, m_ovf, m_unf);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready_o !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL %s ready_wait got %b exp 1", tag, ready_o);
    end
  endtask

  // One request: update model, drive it, check popped value, refill ready drop and settled state.
  task automatic do_op(input logic p, input logic q, input logic [DATA_W-1:0] d, input string tag);
    int  sz;
    logic refill;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    wait_ready({tag, "_pre"});
    sz = mdl.size();
    refill = q && !p && sz >= 2;
    if (p && !q) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else mdl.push_back(d);
    end else if (q && !p) begin
      if (sz == 0) begin
        m_unf = 1'b1;
        exp_q.push_back('0);
      end else begin
        exp_q.push_back(mdl[sz-1]);
        void'(mdl.pop_back());
      end
    end else if (p && q) begin
      if (sz == 0) mdl.push_back(d);
      else begin
        exp_q.push_back(mdl[sz-1]);
        mdl[sz-1] = d;
      end
    end
    push_i = p; pop_i = q; push_data_i = d;
    #1;
    if (q && exp_q.size() > 0 && !(p && sz == 0)) begin
      e = exp_q.pop_front();
      checks++;
      if (tos_data_o !== e) begin
        errors++; $display("FAIL %s pop_value got %h exp %h", tag, tos_data_o, e);
      end
    end
    @(posedge clk);
    #1;
    push_i = 1'b0; pop_i = 1'b0;
    checks++;
    if (ready_o !== !refill) begin
      errors++; $display("FAIL %s ready_after got %b exp %b", tag, ready_o, !refill);
    end
    @(negedge clk);
    wait_ready({tag, "_post"});
    check_state(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || state_o !== ST_IDLE) begin
      errors++; $display("FAIL reset ready/state got %b/%b exp 1/0", ready_o, state_o);
    end
    check_state("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_push3();
    do_op(1, 0, 8'h11, "push_11");
    do_op(1, 0, 8'h22, "push_22");
    do_op(1, 0, 8'h33, "push_33");
    checks++;
    if (dut.u_ram.mem[0] !== 8'h11 || dut.u_ram.mem[1] !== 8'h22) begin
      errors++; $display("FAIL ram_layout got %h,%h exp 11,22", dut.u_ram.mem[0], dut.u_ram.mem[1]);
    end
  endtask

  task automatic test_pop();
    do_op(0, 1, 8'h00, "pop_33");
    do_op(0, 1, 8'h00, "pop_22");
    do_op(0, 1, 8'h00, "pop_11");
  endtask

  task automatic test_underflow();
    do_op(0, 1, 8'h00, "pop_empty");
    @(negedge clk);
    clr_err_i = 1'b1;
    m_unf = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    clr_err_i = 1'b0;
    @(negedge clk);
    check_state("clr_err");
  endtask

  task automatic test_full_lifo();
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, 8'($urandom_range(0, 255)), "fill");
    do_op(1, 0, 8'hEE, "push_full");
    do_op(1, 1, 8'h5A, "replace_full");
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 8'h00, "drain");
    @(negedge clk);
    clr_err_i = 1'b1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1;
    clr_err_i = 1'b0;
  endtask

  task automatic test_replace();
    do_op(1, 0, 8'h05, "push_05");
    do_op(1, 1, 8'h09, "replace_09");
    do_op(0, 1, 8'h00, "pop_09");
    do_op(1, 1, 8'h44, "replace_empty");
  endtask

  task automatic test_reset_refill();
    do_op(1, 0, 8'hA1, "push_a1");
    do_op(1, 0, 8'hA2, "push_a2");
    @(negedge clk);
    pop_i = 1'b1;
    @(posedge clk);
    #1;
    pop_i = 1'b0;
    checks++;
    if (state_o !== ST_REFILL) begin
      errors++; $display("FAIL refill_entry state got %b exp 1", state_o);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ready_o !== 1'b1 || count_o !== '0 || tos_data_o !== '0) begin
      errors++; $display("FAIL reset_mid_refill got rdy=%b cnt=%0d tos=%h exp 1,0,00",
                         ready_o, count_o, tos_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("after_reset_release");
  endtask

  initial begin
    test_reset();
    test_push3();
    test_pop();
    test_underflow();
    test_full_lifo();
    test_replace();
    test_reset_refill();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
